// File: rtl/ps2_kbd_pkg.sv
// ============================================================================
// Module : ps2_kbd_pkg
// Brief  : Scan-code constants, letter map and FSM state types for the PS/2
//          keystroke decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam logic [4:0] KEY_ENTER = 5'b11111;
  // {valid, code}: valid=0 marks a scan code with no letter assigned
  localparam logic [5:0] KEY_NONE  = 6'b0_00000;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORMAL    = 2'd0,
    DEC_BREAK     = 2'd1,
    DEC_EXT       = 2'd2,
    DEC_EXT_BREAK = 2'd3
  } dec_state_t;

  function automatic logic [5:0] map_scancode(input logic [7:0] sc);
    logic [5:0] m;
    m = KEY_NONE;
    case (sc)
      8'h1C:    m = {1'b1, 5'd0};
      8'h32:    m = {1'b1, 5'd1};
      8'h21:    m = {1'b1, 5'd2};
      8'h23:    m = {1'b1, 5'd3};
      8'h24:    m = {1'b1, 5'd4};
      8'h2B:    m = {1'b1, 5'd5};
      8'h34:    m = {1'b1, 5'd6};
      8'h33:    m = {1'b1, 5'd7};
      8'h43:    m = {1'b1, 5'd8};
      8'h3B:    m = {1'b1, 5'd9};
      8'h42:    m = {1'b1, 5'd10};
      8'h4B:    m = {1'b1, 5'd11};
      8'h3A:    m = {1'b1, 5'd12};
      8'h31:    m = {1'b1, 5'd13};
      8'h44:    m = {1'b1, 5'd14};
      8'h4D:    m = {1'b1, 5'd15};
      8'h15:    m = {1'b1, 5'd16};
      8'h2D:    m = {1'b1, 5'd17};
      8'h1B:    m = {1'b1, 5'd18};
      8'h2C:    m = {1'b1, 5'd19};
      8'h3C:    m = {1'b1, 5'd20};
      8'h2A:    m = {1'b1, 5'd21};
      8'h1D:    m = {1'b1, 5'd22};
      8'h22:    m = {1'b1, 5'd23};
      8'h35:    m = {1'b1, 5'd24};
      8'h1A:    m = {1'b1, 5'd25};
      SC_ENTER: m = {1'b1, KEY_ENTER};
      default:  m = KEY_NONE;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module : ps2_frame_rx
// Brief  : PS/2 pin synchroniser and 11-bit frame receiver with timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_frame_rx
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          r_clk_s1, r_clk_s2, r_clk_d;
  logic          r_dat_s1, r_dat_s2;
  rx_state_t     r_state, w_state_nx;
  logic [3:0]    r_bit_cnt, w_bit_nx;
  logic [9:0]    r_sh, w_sh_nx;
  logic [TW-1:0] r_to_cnt, w_to_nx;
  logic          w_fall, w_vld, w_err;

  // Idle-high reset values keep a false falling edge from appearing after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_d & ~r_clk_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RX_IDLE;
      r_bit_cnt <= '0;
      r_sh      <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_bit_cnt <= w_bit_nx;
      r_sh      <= w_sh_nx;
      r_to_cnt  <= w_to_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bit_nx   = r_bit_cnt;
    w_sh_nx    = r_sh;
    w_to_nx    = r_to_cnt;
    w_vld      = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_to_nx = '0;
        if (w_fall && !r_dat_s2) begin
          w_state_nx = RX_SHIFT;
          w_bit_nx   = '0;
        end
      end
      RX_SHIFT: begin
        if (w_fall) begin
          // LSB arrives first, so shift right; stop bit ends up in [9]
          w_sh_nx  = {r_dat_s2, r_sh[9:1]};
          w_to_nx  = '0;
          w_bit_nx = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd9) w_state_nx = RX_CHECK;
        end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_err      = 1'b1;
          w_to_nx    = '0;
          w_state_nx = RX_IDLE;
        end else begin
          w_to_nx = r_to_cnt + TW'(1);
        end
      end
      RX_CHECK: begin
        if (r_sh[9] && (^r_sh[8:0])) w_vld = 1'b1;
        else                         w_err = 1'b1;
        w_state_nx = RX_IDLE;
      end
      default: w_state_nx = RX_IDLE;
    endcase
  end

  assign o_byte      = r_sh[7:0];
  assign o_byte_vld  = w_vld;
  assign o_frame_err = w_err;

endmodule

`default_nettype wire

// File: rtl/ps2_keystroke_decoder.sv
// ============================================================================
// Module : ps2_keystroke_decoder
// Brief  : PS/2 set-2 key-release decoder producing a letter code and a
//          stretched release strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_keystroke_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int HOLD_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] keystroke,
  output logic       keyReleased,
  output logic       frame_err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [7:0]    w_byte;
  logic          w_byte_vld, w_frame_err;
  logic [5:0]    w_map;
  dec_state_t    r_dec, w_dec_nx;
  logic          w_event;

  logic [4:0]    r_keystroke;
  logic          r_key_rel;
  logic          r_fire;
  logic          r_pend_vld;
  logic [4:0]    r_pend_code;
  logic [HW-1:0] r_hold_cnt;
  logic          w_have;
  logic [4:0]    w_have_code;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_byte      (w_byte),
    .o_byte_vld  (w_byte_vld),
    .o_frame_err (w_frame_err)
  );

  assign w_map = map_scancode(w_byte);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_dec <= DEC_NORMAL;
    else        r_dec <= w_dec_nx;
  end

  always_comb begin
    w_dec_nx = r_dec;
    w_event  = 1'b0;
    if (w_frame_err) begin
      w_dec_nx = DEC_NORMAL;
    end else if (w_byte_vld) begin
      case (r_dec)
        DEC_NORMAL: begin
          if (w_byte == SC_BREAK)    w_dec_nx = DEC_BREAK;
          else if (w_byte == SC_EXT) w_dec_nx = DEC_EXT;
        end
        DEC_BREAK: begin
          w_event  = w_map[5];
          w_dec_nx = DEC_NORMAL;
        end
        DEC_EXT: begin
          w_dec_nx = (w_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
        end
        default: w_dec_nx = DEC_NORMAL;
      endcase
    end
  end

  // A code may only be loaded while the strobe is idle and not about to rise
  assign w_have      = w_event | r_pend_vld;
  assign w_have_code = w_event ? w_map[4:0] : r_pend_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_keystroke <= '0;
      r_key_rel   <= 1'b0;
      r_fire      <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_fire <= 1'b0;
      if (w_have && !r_key_rel && !r_fire) begin
        r_keystroke <= w_have_code;
        r_fire      <= 1'b1;
        r_pend_vld  <= 1'b0;
      end else if (w_event) begin
        r_pend_vld  <= 1'b1;
        r_pend_code <= w_map[4:0];
      end

      if (r_fire) begin
        r_key_rel  <= 1'b1;
        r_hold_cnt <= HW'(HOLD_CYCLES - 1);
      end else if (r_key_rel) begin
        if (r_hold_cnt == '0) r_key_rel  <= 1'b0;
        else                  r_hold_cnt <= r_hold_cnt - HW'(1);
      end
    end
  end

  assign keystroke   = r_keystroke;
  assign keyReleased = r_key_rel;
  assign frame_err   = w_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keystroke_decoder.sv
// ============================================================================
// Module : tb_ps2_keystroke_decoder
// Brief  : Directed self-checking bench for ps2_keystroke_decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_keystroke_decoder;

  localparam int HALF = 20;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] keystroke;
  logic       keyReleased;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int ev_cnt = 0;
  int last_code = 0;
  int hi_len = 0;
  int last_len = 0;
  int stab_bad = 0;
  int err_run = 0;
  int err_cnt = 0;
  int err_max = 0;
  logic kr_q = 1'b0;

  ps2_keystroke_decoder #(
    .TIMEOUT_CYCLES (200),
    .HOLD_CYCLES    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keystroke   (keystroke),
    .keyReleased (keyReleased),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe / error-pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (keyReleased && !kr_q) begin
      ev_cnt    <= ev_cnt + 1;
      last_code <= int'(keystroke);
      rise_cyc  <= cyc;
      hi_len    <= 1;
    end else if (keyReleased) begin
      hi_len <= hi_len + 1;
      if (int'(keystroke) != last_code) stab_bad <= stab_bad + 1;
    end else if (kr_q) begin
      last_len <= hi_len;
    end
    kr_q <= keyReleased;
    if (frame_err) begin
      err_run <= err_run + 1;
    end else if (err_run != 0) begin
      err_cnt <= err_cnt + 1;
      if (err_run > err_max) err_max <= err_run;
      err_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      #1;
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  int ev0, er0;

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_keystroke", 32'(keystroke), 32'd0);
    chk("rst_keyrel",    32'(keyReleased), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);

    // 1: make code alone, then break -> 'A'
    ev0 = ev_cnt;
    send_frame(8'h1C, 0, 11);
    chk("t1_make_no_event", 32'(ev_cnt - ev0), 32'd0);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1C, 0, 11);
    repeat (10) @(posedge clk);
    chk("t1_events",  32'(ev_cnt - ev0), 32'd1);
    chk("t1_code",    32'(last_code), 32'd0);
    chk("t1_hold",    32'(last_len), 32'd4);
    chk("t1_latency", 32'(rise_cyc - fall_cyc), 32'd5);

    // 2: Enter, then typematic Z followed by its release
    ev0 = ev_cnt;
    send_frame(8'hF0, 0, 11);
    send_frame(8'h5A, 0, 11);
    chk("t2_enter_ev",   32'(ev_cnt - ev0), 32'd1);
    chk("t2_enter_code", 32'(last_code), 32'd31);
    ev0 = ev_cnt;
    send_frame(8'h1A, 0, 11);
    send_frame(8'h1A, 0, 11);
    send_frame(8'h1A, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1A, 0, 11);
    chk("t2_z_ev",   32'(ev_cnt - ev0), 32'd1);
    chk("t2_z_code", 32'(last_code), 32'd25);

    // 3: break prefix lost to a parity error
    ev0 = ev_cnt; er0 = err_cnt;
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1C, 1, 11);
    send_frame(8'h1C, 0, 11);
    chk("t3_err_cnt",   32'(err_cnt - er0), 32'd1);
    chk("t3_err_width", 32'(err_max), 32'd1);
    chk("t3_no_event",  32'(ev_cnt - ev0), 32'd0);

    // 4: truncated frame times out, then 'E' release
    ev0 = ev_cnt; er0 = err_cnt;
    send_frame(8'h24, 0, 6);
    repeat (300) @(posedge clk);
    chk("t4_timeout_err", 32'(err_cnt - er0), 32'd1);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h24, 0, 11);
    chk("t4_ev",   32'(ev_cnt - ev0), 32'd1);
    chk("t4_code", 32'(last_code), 32'd4);

    // 5: keypad Enter and Esc releases are not letters
    ev0 = ev_cnt;
    send_frame(8'hE0, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h5A, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h76, 0, 11);
    chk("t5_no_event", 32'(ev_cnt - ev0), 32'd0);

    // 6: reset mid-frame after a break prefix
    ev0 = ev_cnt;
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1C, 0, 4);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_keystroke", 32'(keystroke), 32'd0);
    chk("t6_rst_keyrel",    32'(keyReleased), 32'd0);
    chk("t6_rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h1C, 0, 11);
    repeat (10) @(posedge clk);
    chk("t6_no_event", 32'(ev_cnt - ev0), 32'd0);

    chk("key_stable_while_strobe", 32'(stab_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
